sram_access_arbiter: RTL

//  Shares one single-port, multi-cycle data SRAM between the IF-stage fetch port
//  and the MEM-stage load/store port of the 5-stage ARM pipeline.

---
 rtl/sram_access_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - IF/MEM arbiter for one shared multi-cycle data SRAM (option: RR_FAIRNESS_EN)
`timescale 1ns/1ps

module sram_access_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter reload: the access lasts ACCESS_CYCLES cycles, ending when cnt hits 0
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        owner_mem;     // owner of the current (or most recent) access
    logic        mem_req;
    logic        any_req;
    logic        grant_mem;
    logic [ADDR_W-1:0] if_word;
    logic [ADDR_W-1:0] mem_word;
    logic        unused_addr_bits;

    // Byte addresses are reduced to SRAM word addresses; the rest is dropped
    assign if_word  = if_addr[ADDR_W+1:2];
    assign mem_word = mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign mem_req = mem_r_en | mem_w_en;
    assign any_req = if_req | mem_req;

    // Grant decision for the IDLE cycle
    always_comb begin
        grant_mem = 1'b0;
`ifdef RR_FAIRNESS_EN
        // On contention hand the SRAM to whichever port did not own it last
        if (mem_req && if_req)
            grant_mem = ~owner_mem;
        else
            grant_mem = mem_req;
`else
        // Load/store always beats fetch; fetch may starve under continuous MEM traffic
        grant_mem = mem_req;
`endif
    end

    // Pipeline hold signals: forced low while the block is held in reset
    always_comb begin
        if_stall = rst & if_req & ~if_ready;
        freeze   = rst & mem_req & ~mem_ready;
    end

    // Access sequencer: IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            owner_mem  <= 1'b0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= 32'd0;
            mem_rdata  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    if_rdata  <= 32'd0;
                    mem_rdata <= 32'd0;
                    if (any_req) begin
                        state     <= ST_ACCESS;
                        owner_mem <= grant_mem;
                        cnt       <= CNT_LOAD;
                        sram_ce   <= 1'b1;
                        // A simultaneous read+write request is handled as a store
                        sram_we   <= grant_mem & mem_w_en;
                        if (grant_mem) begin
                            sram_addr  <= mem_word;
                            sram_wdata <= mem_w_en ? mem_wdata : 32'd0;
                        end else begin
                            sram_addr  <= if_word;
                            sram_wdata <= 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_DONE;
                        sram_ce   <= 1'b0;
                        sram_we   <= 1'b0;
                        if_ready  <= ~owner_mem;
                        mem_ready <= owner_mem;
                        // Read data is only valid in the final access cycle
                        if_rdata  <= owner_mem ? 32'd0 : sram_rdata;
                        mem_rdata <= (owner_mem && !sram_we) ? sram_rdata : 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    if_rdata  <= 32'd0;
                    mem_rdata <= 32'd0;
                end
                default: begin
                    state   <= ST_IDLE;
                    sram_ce <= 1'b0;
                    sram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
